// File: rtl/uart_instr_loader_if.sv
// Instruction-memory write port driven by the UART loader.
// The loader holds the master side; the instruction RAM or a monitor holds the slave side.
interface uart_instr_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] max_addr;

    modport master (output wr_en, output wr_addr, output wr_data, output max_addr);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  max_addr);
endinterface

// File: rtl/uart_instr_loader.sv
// UART receive-and-load engine: deserialises frames from the RXD pin, packs the
// received bytes into instruction words and writes them to sequential addresses
// of the instruction RAM. The transfer is declared done after a quiet period.
module uart_instr_loader #(
    parameter int CLK_FREQ       = 100000000,
    parameter int BAUD_RATE      = 115200,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int BYTES_PER_WORD = 2,
    parameter int ADDR_WIDTH     = 8,
    parameter int START_ADDR     = 1,
    parameter int IDLE_TIMEOUT   = 200000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    input  logic                 i_enable,
    uart_instr_loader_if.master  mem,
    output logic                 o_byte_valid,
    output logic [DATA_BITS-1:0] o_byte,
    output logic                 o_busy,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overflow,
    output logic                 o_done
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CLK_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W        = $clog2(DATA_BITS + 1);
    localparam int BYTE_W       = $clog2(BYTES_PER_WORD + 1);
    localparam int IDLE_W       = $clog2(IDLE_TIMEOUT + 1);
    localparam int WORD_W       = BYTES_PER_WORD * DATA_BITS;

    localparam logic [CLK_W-1:0]      BIT_LAST   = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0]      HALF_LAST  = CLK_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0]      DATA_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BYTE_W-1:0]     BYTE_LAST  = BYTE_W'(BYTES_PER_WORD - 1);
    localparam logic [IDLE_W-1:0]     IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP   = '1;
    localparam logic                  ODD_PAR    = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_sync;
    logic                   rx_prev;
    logic [CLK_W-1:0]       clk_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   parity_ok;
    logic [BYTE_W-1:0]      byte_cnt;
    logic [WORD_W-1:0]      word_reg;
    logic                   word_ready;
    logic [ADDR_WIDTH-1:0]  next_addr;
    logic                   addr_full;
    logic                   wrote_any;
    logic [IDLE_W-1:0]      idle_cnt;

    // Bring the asynchronous RXD line into the clock domain and keep the previous
    // synchronised value so the start-bit falling edge can be detected.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receive FSM, word packer, address sequencer and idle timeout in one process;
    // a completed word is flagged at the stop sample and written on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            clk_cnt      <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            parity_ok    <= 1'b1;
            byte_cnt     <= '0;
            word_reg     <= '0;
            word_ready   <= 1'b0;
            next_addr    <= ADDR_FIRST;
            addr_full    <= 1'b0;
            wrote_any    <= 1'b0;
            idle_cnt     <= '0;
            o_byte_valid <= 1'b0;
            o_byte       <= '0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overflow   <= 1'b0;
            o_done       <= 1'b0;
            mem.wr_en    <= 1'b0;
            mem.wr_addr  <= ADDR_FIRST;
            mem.wr_data  <= '0;
            mem.max_addr <= '0;
        end else begin
            o_byte_valid <= 1'b0;
            mem.wr_en    <= 1'b0;
            word_ready   <= 1'b0;

            if (word_ready) begin
                if (addr_full) begin
                    o_overflow <= 1'b1;
                end else begin
                    mem.wr_en    <= 1'b1;
                    mem.wr_addr  <= next_addr;
                    mem.wr_data  <= word_reg;
                    mem.max_addr <= next_addr;
                    wrote_any    <= 1'b1;
                    if (next_addr == ADDR_TOP) begin
                        addr_full <= 1'b1;
                    end else begin
                        next_addr <= next_addr + ADDR_WIDTH'(1);
                    end
                end
            end

            if (!i_enable) begin
                state    <= ST_IDLE;
                clk_cnt  <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                idle_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!o_done && rx_prev && !rx_sync) begin
                            state     <= ST_START;
                            clk_cnt   <= '0;
                            bit_cnt   <= '0;
                            parity_ok <= 1'b1;
                        end else if (wrote_any && !o_done) begin
                            if (idle_cnt == IDLE_LAST) begin
                                o_done   <= 1'b1;
                                byte_cnt <= '0;
                            end else begin
                                idle_cnt <= idle_cnt + IDLE_W'(1);
                            end
                        end
                    end
                    ST_START: begin
                        if (clk_cnt == HALF_LAST) begin
                            clk_cnt <= '0;
                            state   <= rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            clk_cnt <= clk_cnt + CLK_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (clk_cnt == BIT_LAST) begin
                            clk_cnt   <= '0;
                            shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == DATA_LAST) begin
                                state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                            end
                        end else begin
                            clk_cnt <= clk_cnt + CLK_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        if (clk_cnt == BIT_LAST) begin
                            clk_cnt   <= '0;
                            parity_ok <= (rx_sync == ((^shift_reg) ^ ODD_PAR));
                            state     <= ST_STOP;
                        end else begin
                            clk_cnt <= clk_cnt + CLK_W'(1);
                        end
                    end
                    ST_STOP: begin
                        if (clk_cnt == BIT_LAST) begin
                            clk_cnt <= '0;
                            state   <= ST_IDLE;
                            if (!rx_sync) begin
                                o_frame_err <= 1'b1;
                                byte_cnt    <= '0;
                            end else if (!parity_ok) begin
                                o_parity_err <= 1'b1;
                                byte_cnt     <= '0;
                            end else begin
                                o_byte_valid <= 1'b1;
                                o_byte       <= shift_reg;
                                word_reg     <= (word_reg << DATA_BITS) | WORD_W'(shift_reg);
                                idle_cnt     <= '0;
                                if (byte_cnt == BYTE_LAST) begin
                                    byte_cnt   <= '0;
                                    word_ready <= 1'b1;
                                end else begin
                                    byte_cnt <= byte_cnt + BYTE_W'(1);
                                end
                            end
                        end else begin
                            clk_cnt <= clk_cnt + CLK_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_busy = (state != ST_IDLE) || (byte_cnt != '0);

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed bench for uart_instr_loader: three instances cover the no-parity,
// even-parity and tiny-address-space configurations at a scaled baud rate.
module tb_uart_instr_loader;
    localparam int CLK_FREQ = 100000000;
    localparam int BAUD     = 6250000;
    localparam int BIT_NS   = 160;
    localparam int IDLE_TO  = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic rx_a = 1'b1, rx_p = 1'b1, rx_o = 1'b1;

    logic       bv_a, bv_p, bv_o;
    logic [7:0] byte_a, byte_p, byte_o;
    logic       busy_a, busy_p, busy_o;
    logic       ferr_a, ferr_p, ferr_o;
    logic       perr_a, perr_p, perr_o;
    logic       ovf_a, ovf_p, ovf_o;
    logic       done_a, done_p, done_o;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int wa_addr[$], wa_data[$], wa_cyc[$], bva_cyc[$];
    int wp_addr[$], wp_data[$], bvp_cnt = 0;
    int wo_addr[$], bvo_cnt = 0;

    uart_instr_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) mem_a ();
    uart_instr_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) mem_p ();
    uart_instr_loader_if #(.ADDR_WIDTH(2), .DATA_WIDTH(16)) mem_o ();

    uart_instr_loader #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY(0), .ADDR_WIDTH(8),
                        .START_ADDR(1), .IDLE_TIMEOUT(IDLE_TO)) u_a (
        .clk(clk), .rst(rst), .i_rx(rx_a), .i_enable(enable), .mem(mem_a),
        .o_byte_valid(bv_a), .o_byte(byte_a), .o_busy(busy_a), .o_frame_err(ferr_a),
        .o_parity_err(perr_a), .o_overflow(ovf_a), .o_done(done_a));

    uart_instr_loader #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY(1), .ADDR_WIDTH(8),
                        .START_ADDR(1), .IDLE_TIMEOUT(IDLE_TO)) u_p (
        .clk(clk), .rst(rst), .i_rx(rx_p), .i_enable(enable), .mem(mem_p),
        .o_byte_valid(bv_p), .o_byte(byte_p), .o_busy(busy_p), .o_frame_err(ferr_p),
        .o_parity_err(perr_p), .o_overflow(ovf_p), .o_done(done_p));

    uart_instr_loader #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY(0), .ADDR_WIDTH(2),
                        .START_ADDR(1), .IDLE_TIMEOUT(IDLE_TO)) u_o (
        .clk(clk), .rst(rst), .i_rx(rx_o), .i_enable(enable), .mem(mem_o),
        .o_byte_valid(bv_o), .o_byte(byte_o), .o_busy(busy_o), .o_frame_err(ferr_o),
        .o_parity_err(perr_o), .o_overflow(ovf_o), .o_done(done_o));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every byte pulse and memory write seen on each instance.
    always @(negedge clk) begin
        if (bv_a) bva_cyc.push_back(cyc);
        if (mem_a.wr_en) begin
            wa_addr.push_back(int'(mem_a.wr_addr));
            wa_data.push_back(int'(mem_a.wr_data));
            wa_cyc.push_back(cyc);
        end
        if (bv_p) bvp_cnt <= bvp_cnt + 1;
        if (mem_p.wr_en) begin
            wp_addr.push_back(int'(mem_p.wr_addr));
            wp_data.push_back(int'(mem_p.wr_data));
        end
        if (bv_o) bvo_cnt <= bvo_cnt + 1;
        if (mem_o.wr_en) wo_addr.push_back(int'(mem_o.wr_addr));
    end

    task automatic set_rx(input int which, input logic v);
        case (which)
            0: rx_a = v;
            1: rx_p = v;
            default: rx_o = v;
        endcase
    endtask

    task automatic send_frame(input int which, input logic [7:0] data, input bit with_par,
                              input logic par, input logic stop);
        set_rx(which, 1'b0); #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, data[i]); #(BIT_NS);
        end
        if (with_par) begin
            set_rx(which, par); #(BIT_NS);
        end
        set_rx(which, stop); #(BIT_NS);
        set_rx(which, 1'b1); #(BIT_NS);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b1; rx_a = 1'b1; rx_p = 1'b1; rx_o = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; repeat (3) @(negedge clk);
        tests_run++; if (mem_a.wr_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wr_en got %b want 0", mem_a.wr_en); end
        tests_run++; if (mem_a.wr_addr !== 8'd1) begin tests_failed++; $display("[TB] FAIL reset_wr_addr got %0d want 1", mem_a.wr_addr); end
        tests_run++; if (mem_a.max_addr !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_max_addr got %0d want 0", mem_a.max_addr); end
        tests_run++; if ({bv_a, busy_a, ferr_a, perr_a, ovf_a, done_a} !== 6'b0) begin tests_failed++; $display("[TB] FAIL reset_flags got %b want 000000", {bv_a, busy_a, ferr_a, perr_a, ovf_a, done_a}); end
        tests_run++; if (byte_a !== 8'h00 || mem_a.wr_data !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_data got %h/%h want 00/0000", byte_a, mem_a.wr_data); end
        rst = 1'b0; repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word();
        int nw, nb, waited;
        do_reset();
        nw = wa_addr.size(); nb = bva_cyc.size();
        send_frame(0, 8'h41, 0, 1'b0, 1'b1);
        send_frame(0, 8'h26, 0, 1'b0, 1'b1);
        tests_run++; if (bva_cyc.size() - nb != 2) begin tests_failed++; $display("[TB] FAIL word_byte_count got %0d want 2", bva_cyc.size() - nb); end
        tests_run++; if (byte_a !== 8'h26) begin tests_failed++; $display("[TB] FAIL word_last_byte got %h want 26", byte_a); end
        tests_run++;
        if (wa_addr.size() - nw != 1) begin
            tests_failed++; $display("[TB] FAIL word_write_count got %0d want 1", wa_addr.size() - nw);
        end else begin
            tests_run++; if (wa_addr[nw] != 1) begin tests_failed++; $display("[TB] FAIL word_addr got %0d want 1", wa_addr[nw]); end
            tests_run++; if (wa_data[nw] != 'h4126) begin tests_failed++; $display("[TB] FAIL word_data got %h want 4126", wa_data[nw]); end
            tests_run++; if (wa_cyc[nw] != bva_cyc[bva_cyc.size()-1] + 1) begin tests_failed++; $display("[TB] FAIL word_strobe_latency got %0d want %0d", wa_cyc[nw], bva_cyc[bva_cyc.size()-1] + 1); end
        end
        tests_run++; if (mem_a.max_addr !== 8'd1) begin tests_failed++; $display("[TB] FAIL word_max_addr got %0d want 1", mem_a.max_addr); end
        repeat (IDLE_TO - 150) @(negedge clk);
        tests_run++; if (done_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL done_early got %b want 0", done_a); end
        waited = 0;
        while (done_a !== 1'b1 && waited < 300) begin @(negedge clk); waited++; end
        tests_run++; if (done_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL done_timeout got %b want 1", done_a); end
        tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL done_busy got %b want 0", busy_a); end
    endtask

    task automatic test_program();
        logic [7:0] prog [22];
        int nw, exp_data;
        prog = '{8'h41, 8'h26, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01,
                 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h55, 8'hAA, 8'hE0, 8'h00};
        do_reset();
        nw = wa_addr.size();
        for (int i = 0; i < 22; i++) send_frame(0, prog[i], 0, 1'b0, 1'b1);
        tests_run++;
        if (wa_addr.size() - nw != 11) begin
            tests_failed++; $display("[TB] FAIL prog_write_count got %0d want 11", wa_addr.size() - nw);
        end else begin
            for (int w = 0; w < 11; w++) begin
                exp_data = {16'h0, prog[2*w], prog[2*w+1]};
                tests_run++;
                if (wa_addr[nw+w] != w + 1 || wa_data[nw+w] != exp_data) begin
                    tests_failed++;
                    $display("[TB] FAIL prog_word%0d got %0d:%h want %0d:%h", w, wa_addr[nw+w], wa_data[nw+w], w + 1, exp_data);
                end
            end
        end
        tests_run++; if (mem_a.max_addr !== 8'd11) begin tests_failed++; $display("[TB] FAIL prog_max_addr got %0d want 11", mem_a.max_addr); end
        tests_run++; if ({ferr_a, perr_a, ovf_a} !== 3'b0) begin tests_failed++; $display("[TB] FAIL prog_flags got %b want 000", {ferr_a, perr_a, ovf_a}); end
    endtask

    task automatic test_glitch();
        int nb;
        do_reset();
        nb = bva_cyc.size();
        rx_a = 1'b0; #50; rx_a = 1'b1;
        repeat (40) @(negedge clk);
        tests_run++; if (bva_cyc.size() != nb) begin tests_failed++; $display("[TB] FAIL glitch_byte got %0d want 0", bva_cyc.size() - nb); end
        tests_run++; if ({ferr_a, perr_a, busy_a} !== 3'b0) begin tests_failed++; $display("[TB] FAIL glitch_state got %b want 000", {ferr_a, perr_a, busy_a}); end
    endtask

    task automatic test_frame_err();
        int nw;
        do_reset();
        nw = wa_addr.size();
        send_frame(0, 8'h41, 0, 1'b0, 1'b0);
        tests_run++; if (ferr_a !== 1'b1 || busy_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_err got ferr=%b busy=%b want 1/0", ferr_a, busy_a); end
        send_frame(0, 8'h41, 0, 1'b0, 1'b1);
        send_frame(0, 8'h00, 0, 1'b0, 1'b1);
        tests_run++;
        if (wa_addr.size() - nw != 1) begin
            tests_failed++; $display("[TB] FAIL frame_write_count got %0d want 1", wa_addr.size() - nw);
        end else if (wa_addr[nw] != 1 || wa_data[nw] != 'h4100) begin
            tests_failed++; $display("[TB] FAIL frame_write got %0d:%h want 1:4100", wa_addr[nw], wa_data[nw]);
        end
    endtask

    task automatic test_parity();
        int nw, nb;
        do_reset();
        nw = wp_addr.size(); nb = bvp_cnt;
        send_frame(1, 8'h41, 1, 1'b1, 1'b1);
        tests_run++; if (perr_p !== 1'b1 || bvp_cnt != nb) begin tests_failed++; $display("[TB] FAIL parity_err got perr=%b bytes=%0d want 1/0", perr_p, bvp_cnt - nb); end
        send_frame(1, 8'h41, 1, 1'b0, 1'b1);
        send_frame(1, 8'h00, 1, 1'b0, 1'b1);
        tests_run++;
        if (wp_addr.size() - nw != 1) begin
            tests_failed++; $display("[TB] FAIL parity_write_count got %0d want 1", wp_addr.size() - nw);
        end else if (wp_addr[nw] != 1 || wp_data[nw] != 'h4100) begin
            tests_failed++; $display("[TB] FAIL parity_write got %0d:%h want 1:4100", wp_addr[nw], wp_data[nw]);
        end
        tests_run++; if (ferr_p !== 1'b0) begin tests_failed++; $display("[TB] FAIL parity_no_frame_err got %b want 0", ferr_p); end
    endtask

    task automatic test_overflow();
        int nw, nb, waited;
        do_reset();
        nw = wo_addr.size();
        for (int i = 0; i < 8; i++) send_frame(2, 8'(8'h10 + i), 0, 1'b0, 1'b1);
        tests_run++;
        if (wo_addr.size() - nw != 3) begin
            tests_failed++; $display("[TB] FAIL ovf_write_count got %0d want 3", wo_addr.size() - nw);
        end else if (wo_addr[nw] != 1 || wo_addr[nw+1] != 2 || wo_addr[nw+2] != 3) begin
            tests_failed++; $display("[TB] FAIL ovf_addrs got %0d,%0d,%0d want 1,2,3", wo_addr[nw], wo_addr[nw+1], wo_addr[nw+2]);
        end
        tests_run++; if (ovf_o !== 1'b1 || mem_o.max_addr !== 2'd3) begin tests_failed++; $display("[TB] FAIL ovf_flag got ovf=%b max=%0d want 1/3", ovf_o, mem_o.max_addr); end
        waited = 0;
        while (done_o !== 1'b1 && waited < 800) begin @(negedge clk); waited++; end
        tests_run++; if (done_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_done got %b want 1", done_o); end
        nb = bvo_cnt;
        send_frame(2, 8'h41, 0, 1'b0, 1'b1);
        tests_run++; if (bvo_cnt != nb || busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL after_done_ignored got bytes=%0d busy=%b want 0/0", bvo_cnt - nb, busy_o); end
        do_reset();
        tests_run++; if (mem_o.wr_addr !== 2'd1 || {ovf_o, done_o, ferr_o, perr_o} !== 4'b0) begin tests_failed++; $display("[TB] FAIL ovf_reset got addr=%0d flags=%b want 1/0000", mem_o.wr_addr, {ovf_o, done_o, ferr_o, perr_o}); end
    endtask

    task automatic test_enable_abort();
        int nw;
        do_reset();
        nw = wa_addr.size();
        send_frame(0, 8'h41, 0, 1'b0, 1'b1);
        tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_partial_busy got %b want 1", busy_a); end
        rx_a = 1'b0; #(BIT_NS * 3);
        enable = 1'b0; #(BIT_NS);
        rx_a = 1'b1; #(BIT_NS * 2);
        tests_run++; if ({busy_a, ferr_a, perr_a} !== 3'b0) begin tests_failed++; $display("[TB] FAIL abort_state got %b want 000", {busy_a, ferr_a, perr_a}); end
        enable = 1'b1; #(BIT_NS);
        send_frame(0, 8'h00, 0, 1'b0, 1'b1);
        send_frame(0, 8'h12, 0, 1'b0, 1'b1);
        tests_run++;
        if (wa_addr.size() - nw != 1) begin
            tests_failed++; $display("[TB] FAIL abort_write_count got %0d want 1", wa_addr.size() - nw);
        end else if (wa_addr[nw] != 1 || wa_data[nw] != 'h0012) begin
            tests_failed++; $display("[TB] FAIL abort_write got %0d:%h want 1:0012", wa_addr[nw], wa_data[nw]);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_program();
        test_glitch();
        test_frame_err();
        test_parity();
        test_overflow();
        test_enable_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
